fetch_sequencer: RTL

//  PC and fetch control for the instruction fetch stage; upstream driver of the memory address register.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_sequencer_pc_reg.sv | 32 +++
 rtl/fetch_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   AW_DEF/DW_DEF    default address and instruction widths
//   RESET_PC_DEF     default PC after reset
//   PC_STEP_DEF      default PC increment per fetched word
//   fetch_state_t    fetch sequencer state encoding (3 bits)
package fetch_pkg;

   localparam int unsigned AW_DEF       = 5;
   localparam int unsigned DW_DEF       = 32;
   localparam int unsigned RESET_PC_DEF = 0;
   localparam int unsigned PC_STEP_DEF  = 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_ADDR = 3'd1,
      ISSUE    = 3'd2,
      WAIT     = 3'd3,
      HOLD     = 3'd4,
      DRAIN    = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// pc_reg: program counter with load and increment.
//   clk, rst_n   clock, asynchronous active-low reset (pc <= RESET_PC)
//   load         load pc from load_val (wins over inc)
//   load_val     value to load
//   inc          advance pc by PC_STEP, modulo 2^AW
//   pc           current program counter
module pc_reg
   import fetch_pkg::*;
#(
   parameter int unsigned     AW       = AW_DEF,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter int unsigned     PC_STEP  = PC_STEP_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          inc,
   output logic [AW-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + AW'(PC_STEP);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC and fetch control for the instruction fetch stage.
//   clk, rst_n       clock, asynchronous active-low reset
//   en               fetch enable; low = start no new fetch
//   redirect_valid   redirect request, redirect_pc = target
//   mar_wr, mar_rd   MAR load / MAR drive-to-memory strobes (registered, exclusive)
//   mar_addr         address to MAR input, always equal to pc
//   mem_rdata/rvalid instruction memory read response
//   ir_valid/ready   valid/ready handshake towards decode
//   ir_data, ir_pc   captured instruction and its PC
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned   AW       = AW_DEF,
   parameter int unsigned   DW       = DW_DEF,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
   parameter int unsigned   PC_STEP  = PC_STEP_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          mar_wr,
   output logic          mar_rd,
   output logic [AW-1:0] mar_addr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rvalid,
   output logic          ir_valid,
   input  logic          ir_ready,
   output logic [DW-1:0] ir_data,
   output logic [AW-1:0] ir_pc
);

   fetch_state_t  state;
   fetch_state_t  nxt;
   logic [AW-1:0] pc;
   logic          pc_inc;

   // A redirect in HOLD consumes the word but loads the target instead of pc+step.
   always_comb begin
      pc_inc = (state == HOLD) && ir_ready && !redirect_valid;
   end

   pc_reg #(
      .AW       (AW),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (redirect_valid),
      .load_val (redirect_pc),
      .inc      (pc_inc),
      .pc       (pc)
   );

   assign mar_addr = pc;

   // Redirect takes priority over every other transition.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (en) nxt = SET_ADDR;
         SET_ADDR: nxt = redirect_valid ? SET_ADDR : ISSUE;
         ISSUE:    nxt = redirect_valid ? SET_ADDR : WAIT;
         WAIT: begin
            if (redirect_valid)  nxt = mem_rvalid ? SET_ADDR : DRAIN;
            else if (mem_rvalid) nxt = HOLD;
         end
         HOLD: begin
            if (redirect_valid) nxt = SET_ADDR;
            else if (ir_ready)  nxt = en ? SET_ADDR : IDLE;
         end
         DRAIN: begin
            if (!redirect_valid && mem_rvalid) nxt = en ? SET_ADDR : IDLE;
         end
         default:  nxt = IDLE;
      endcase
   end

   // Moore outputs are registered from the next state so they are valid
   // in the same cycle the state is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mar_wr   <= 1'b0;
         mar_rd   <= 1'b0;
         ir_valid <= 1'b0;
         ir_data  <= '0;
         ir_pc    <= '0;
      end else begin
         state    <= nxt;
         mar_wr   <= (nxt == SET_ADDR);
         mar_rd   <= (nxt == ISSUE);
         ir_valid <= (nxt == HOLD);
         if ((state == WAIT) && mem_rvalid && !redirect_valid) begin
            ir_data <= mem_rdata;
            ir_pc   <= pc;
         end
      end
   end

endmodule
